// File: rtl/imsic_writer_pkg.sv
// ----------------------------------------------------------------------------
// imsic_writer_pkg
// Shared types and constants for the IMSIC MSI AXI writer.
//   wr_state_e : writer FSM states
//   msi_msg_t  : queued MSI message {file, id}. Fields are sized for the
//                largest supported configuration. Narrower ports are
//                zero-extended into them.
//   IMSIC_PAGE_SHIFT, AXI_RESP_OKAY, AXI_BURST_INCR, AXI_SIZE_4B
// ----------------------------------------------------------------------------
package imsic_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } wr_state_e;

    localparam int MSI_FILE_W_MAX = 8;
    localparam int MSI_ID_W_MAX   = 16;

    typedef struct packed {
        logic [MSI_FILE_W_MAX-1:0] file;
        logic [MSI_ID_W_MAX-1:0]   id;
    } msi_msg_t;

    localparam int         IMSIC_PAGE_SHIFT = 12;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B      = 3'b010;

endpackage

// File: rtl/msi_msg_fifo.sv
// ----------------------------------------------------------------------------
// msi_msg_fifo
// Generic synchronous FIFO with full/empty flags. Data is shown at the head
// (data_o), and pop_i consumes it. A push while full is ignored, and so is a
// pop while empty.
// Ports:
//   clk_i, reset_l     clock, async active-low reset
//   push_i, data_i     write side
//   pop_i, data_o      read side (data_o valid when !empty_o)
//   full_o, empty_o    occupancy flags
// ----------------------------------------------------------------------------
module msi_msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_l,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: empty_o gates every use of data_o.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/imsic_msi_axi_writer.sv
// ----------------------------------------------------------------------------
// imsic_msi_axi_writer
// Turns each MSI message {file, id} into one single-beat AXI4 write of the id
// to the seteipnum_le register of the target IMSIC interrupt-file page. Only
// one write is outstanding at a time. Each message retires with a done_o
// pulse, and err_o marks a failed message (bad file index or non-OKAY B).
// Optional build macro: MSI_WRITER_FIFO_EN adds a FIFO_DEPTH-entry queue in
// front of the FSM so messages can be taken while a write is in flight.
// Ports:
//   clk_i, reset_l                     clock, async active-low reset
//   msi_valid_i/msi_ready_o            message handshake
//   msi_file_i, msi_id_i               message payload
//   done_o, err_o                      retire pulses
//   aw_*, w_*, b_*                     AXI4 write channels (master side)
// ----------------------------------------------------------------------------
module imsic_msi_axi_writer
    import imsic_writer_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          AXI_ID_WIDTH   = 10,
    parameter int          AXI_ID         = 0,
    parameter int          NR_INTP_FILES  = 2,
    parameter logic [63:0] IMSIC_BASE     = 64'h0000_0000_2400_0000,
    parameter int          NR_SRC_LEN     = 11,
    parameter int          FIFO_DEPTH     = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_l,
    input  logic                               msi_valid_i,
    output logic                               msi_ready_o,
    input  logic [$clog2(NR_INTP_FILES):0]     msi_file_i,
    input  logic [NR_SRC_LEN-1:0]              msi_id_i,
    output logic                               done_o,
    output logic                               err_o,
    output logic                               aw_valid_o,
    input  logic                               aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]          aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]            aw_id_o,
    output logic [7:0]                         aw_len_o,
    output logic [2:0]                         aw_size_o,
    output logic [1:0]                         aw_burst_o,
    output logic                               w_valid_o,
    input  logic                               w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]          w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]        w_strb_o,
    output logic                               w_last_o,
    input  logic                               b_valid_i,
    output logic                               b_ready_o,
    input  logic [1:0]                         b_resp_i
);

    wr_state_e                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MSI_ID_W_MAX-1:0]  id_q, id_d;
    logic                     aw_vld_q, aw_vld_d;
    logic                     w_vld_q, w_vld_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    msi_msg_t                 msg_in, cur_msg;
    logic                     cur_vld, pop;
    logic [AXI_ADDR_WIDTH-1:0] page_addr;

    assign msg_in = '{file: MSI_FILE_W_MAX'(msi_file_i), id: MSI_ID_W_MAX'(msi_id_i)};

`ifdef MSI_WRITER_FIFO_EN
    logic fifo_full, fifo_empty;

    msi_msg_fifo #(
        .WIDTH ($bits(msi_msg_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_l (reset_l),
        .push_i  (msi_valid_i),
        .data_i  (msg_in),
        .pop_i   (pop),
        .data_o  (cur_msg),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign msi_ready_o = ~fifo_full;
    assign cur_vld     = ~fifo_empty;
`else
    // Without the queue the FSM takes the message straight off the port, and
    // only while idle.
    assign msi_ready_o = (state_q == IDLE);
    assign cur_vld     = msi_valid_i;
    assign cur_msg     = msg_in;

    // FIFO_DEPTH only shapes the queued build. It is kept visible here so both
    // builds elaborate the same parameter set.
    if (FIFO_DEPTH < 1) begin : g_no_queue_depth
    end
`endif

    assign pop = (state_q == IDLE) & cur_vld;

    // The address add is AXI_ADDR_WIDTH wide and wraps silently on overflow.
    assign page_addr = AXI_ADDR_WIDTH'(IMSIC_BASE)
                     + (AXI_ADDR_WIDTH'(cur_msg.file) << IMSIC_PAGE_SHIFT);

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            aw_vld_q <= aw_vld_d;
            w_vld_q  <= w_vld_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        aw_vld_d  = aw_vld_q;
        w_vld_d   = w_vld_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        b_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (cur_msg.file >= MSI_FILE_W_MAX'(NR_INTP_FILES)) begin
                        // No such interrupt file: retire as failed without bus traffic.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        addr_d   = page_addr;
                        id_d     = cur_msg.id;
                        aw_vld_d = 1'b1;
                        w_vld_d  = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            SEND: begin
                // AW and W retire independently and in any order.
                if (aw_ready_i) aw_vld_d = 1'b0;
                if (w_ready_i)  w_vld_d  = 1'b0;
                if (!aw_vld_d && !w_vld_d) state_d = RESP;
            end
            RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    done_d  = 1'b1;
                    err_d   = (b_resp_i != AXI_RESP_OKAY);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_o     = done_q;
    assign err_o      = err_q;
    assign aw_valid_o = aw_vld_q;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = AXI_SIZE_4B;
    assign aw_burst_o = AXI_BURST_INCR;
    assign w_valid_o  = w_vld_q;
    assign w_data_o   = AXI_DATA_WIDTH'(id_q);
    assign w_strb_o   = {{(AXI_DATA_WIDTH/8-4){1'b0}}, 4'hF};
    assign w_last_o   = 1'b1;

endmodule

// File: tb/tb_imsic_msi_axi_writer.sv
module tb_imsic_msi_axi_writer;

    logic        clk_i = 1'b0;
    logic        reset_l = 1'b0;
    logic        msi_valid_i = 1'b0;
    logic        msi_ready_o;
    logic [1:0]  msi_file_i = '0;
    logic [10:0] msi_id_i = '0;
    logic        done_o, err_o;
    logic        aw_valid_o, aw_ready_i = 1'b0;
    logic [63:0] aw_addr_o;
    logic [9:0]  aw_id_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic        w_valid_o, w_ready_i = 1'b0;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o;
    logic        b_valid_i = 1'b0, b_ready_o;
    logic [1:0]  b_resp_i = '0;

    imsic_msi_axi_writer dut (
        .clk_i       (clk_i),
        .reset_l     (reset_l),
        .msi_valid_i (msi_valid_i),
        .msi_ready_o (msi_ready_o),
        .msi_file_i  (msi_file_i),
        .msi_id_i    (msi_id_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready_i),
        .aw_addr_o   (aw_addr_o),
        .aw_id_o     (aw_id_o),
        .aw_len_o    (aw_len_o),
        .aw_size_o   (aw_size_o),
        .aw_burst_o  (aw_burst_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .w_data_o    (w_data_o),
        .w_strb_o    (w_strb_o),
        .w_last_o    (w_last_o),
        .b_valid_i   (b_valid_i),
        .b_ready_o   (b_ready_o),
        .b_resp_i    (b_resp_i)
    );

    always #5 clk_i = ~clk_i;

`ifdef MSI_WRITER_FIFO_EN
    localparam int Q_LAT = 1;
`else
    localparam int Q_LAT = 0;
`endif

    typedef struct {
        logic [1:0]  file;
        logic [10:0] id;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic [1:0]  resp;
        logic [63:0] exp_addr;
        logic        exp_err;
        logic        exp_bad;
    } vec_t;

    vec_t        vecs [8];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] aw_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Presents one message, plays the
    // AXI slave with the vector's delays and checks the retire timing.
    task automatic run_vec(input vec_t v, input string tag);
        int   exp_done, exp_vld, done_cyc, b_cyc, aw_c, w_c, n_aw, n_w, n_b, n_vld;
        logic got_err, rdy_done, addr_ok, data_ok;
        exp_vld  = v.exp_bad ? 0 : ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1;
        exp_done = v.exp_bad ? 1 + Q_LAT
                 : 1 + Q_LAT + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1 + v.b_dly + 1;
        done_cyc = -1; b_cyc = -1; aw_c = -1; w_c = -1;
        n_aw = 0; n_w = 0; n_b = 0; n_vld = 0;
        got_err = 1'b0; rdy_done = 1'b0; addr_ok = 1'b1; data_ok = 1'b1;
        chk({tag, "_ready"}, 64'(msi_ready_o), 64'd1);
        msi_valid_i = 1'b1;
        msi_file_i  = v.file;
        msi_id_i    = v.id;
        @(negedge clk_i);
        msi_valid_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done_o) begin
                done_cyc = c;
                got_err  = err_o;
                rdy_done = msi_ready_o;
                break;
            end
            aw_ready_i = (c >= 1 + Q_LAT + v.aw_dly);
            w_ready_i  = (c >= 1 + Q_LAT + v.w_dly);
            b_valid_i  = (c == b_cyc);
            b_resp_i   = v.resp;
            if (aw_valid_o || w_valid_o) n_vld++;
            if (aw_valid_o && aw_addr_o !== v.exp_addr) addr_ok = 1'b0;
            if (w_valid_o && (w_data_o !== 64'(v.id) || w_strb_o !== 8'h0F)) data_ok = 1'b0;
            if (aw_valid_o && aw_ready_i) begin n_aw++; aw_c = c; end
            if (w_valid_o && w_ready_i) begin n_w++; w_c = c; end
            if (b_valid_i && b_ready_o) n_b++;
            if (aw_c > 0 && w_c > 0 && b_cyc < 0)
                b_cyc = ((aw_c > w_c) ? aw_c : w_c) + 1 + v.b_dly;
            @(negedge clk_i);
        end
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        b_valid_i  = 1'b0;
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({tag, "_err"}, 64'(got_err), 64'(v.exp_err));
        chk({tag, "_ready_at_done"}, 64'(rdy_done), 64'd1);
        chk({tag, "_n_aw"}, 64'(n_aw), v.exp_bad ? 64'd0 : 64'd1);
        chk({tag, "_n_w"}, 64'(n_w), v.exp_bad ? 64'd0 : 64'd1);
        chk({tag, "_n_b"}, 64'(n_b), v.exp_bad ? 64'd0 : 64'd1);
        chk({tag, "_valid_cycles"}, 64'(n_vld), 64'(exp_vld));
        chk({tag, "_addr"}, 64'(addr_ok), 64'd1);
        chk({tag, "_data_strb"}, 64'(data_ok), 64'd1);
    endtask

    initial begin
        int n_done;
        //           file  id       awd wd bd resp   exp_addr                err   bad
        vecs[0] = '{2'd1, 11'd5,     0, 0, 0, 2'b00, 64'h0000_0000_2400_1000, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 11'h7FF,   3, 0, 0, 2'b00, 64'h0000_0000_2400_1000, 1'b0, 1'b0};
        vecs[2] = '{2'd0, 11'd0,     0, 2, 1, 2'b00, 64'h0000_0000_2400_0000, 1'b0, 1'b0};
        vecs[3] = '{2'd2, 11'd9,     0, 0, 0, 2'b00, 64'h0,                   1'b1, 1'b1};
        vecs[4] = '{2'd0, 11'h123,   0, 0, 0, 2'b10, 64'h0000_0000_2400_0000, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 11'h400,   2, 2, 0, 2'b11, 64'h0000_0000_2400_1000, 1'b1, 1'b0};
        vecs[6] = '{2'd3, 11'd1,     0, 0, 0, 2'b00, 64'h0,                   1'b1, 1'b1};
        vecs[7] = '{2'd1, 11'd1,     1, 0, 2, 2'b01, 64'h0000_0000_2400_1000, 1'b1, 1'b0};

        // Reset state.
        #12;
        chk("rst_msi_ready", 64'(msi_ready_o), 64'd1);
        chk("rst_aw_valid", 64'(aw_valid_o), 64'd0);
        chk("rst_w_valid", 64'(w_valid_o), 64'd0);
        chk("rst_b_ready", 64'(b_ready_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_aw_addr", aw_addr_o, 64'd0);
        chk("rst_w_data", w_data_o, 64'd0);
        chk("const_aw_len", 64'(aw_len_o), 64'd0);
        chk("const_aw_size", 64'(aw_size_o), 64'd2);
        chk("const_aw_burst", 64'(aw_burst_o), 64'd1);
        chk("const_w_last", 64'(w_last_o), 64'd1);
        chk("const_aw_id", 64'(aw_id_o), 64'd0);
        @(negedge clk_i);
        reset_l = 1'b1;
        @(negedge clk_i);

        // Vectors run back-to-back: each one starts on the done cycle of the last.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while a write is pending in SEND.
        @(negedge clk_i);
        msi_valid_i = 1'b1;
        msi_file_i  = 2'd1;
        msi_id_i    = 11'd3;
        @(negedge clk_i);
        msi_valid_i = 1'b0;
        for (int c = 0; c < 4 && !aw_valid_o; c++) @(negedge clk_i);
        chk("rst_mid_pre_aw_valid", 64'(aw_valid_o), 64'd1);
        #2 reset_l = 1'b0;
        #1;
        chk("rst_mid_aw_valid", 64'(aw_valid_o), 64'd0);
        chk("rst_mid_w_valid", 64'(w_valid_o), 64'd0);
        chk("rst_mid_msi_ready", 64'(msi_ready_o), 64'd1);
        @(negedge clk_i);
        reset_l = 1'b1;
        n_done = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o) n_done++;
        end
        chk("rst_mid_no_done", 64'(n_done), 64'd0);
        run_vec(vecs[0], "post_rst");

`ifdef MSI_WRITER_FIFO_EN
        // B stalled: the FSM holds message 0 and the queue fills with 1 and 2,
        // so message 3 has to wait until message 0 retires.
        aw_ready_i = 1'b1;
        w_ready_i  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fifo_accept%0d", k), 64'(msi_ready_o), 64'd1);
            msi_valid_i = 1'b1;
            msi_file_i  = 2'(k % 2);
            msi_id_i    = 11'(k + 1);
            @(negedge clk_i);
        end
        msi_file_i = 2'd1;
        msi_id_i   = 11'd4;
        chk("fifo_full_stall", 64'(msi_ready_o), 64'd0);
        n_done = 0;
        for (int c = 0; c < 60 && n_done < 4; c++) begin
            logic took;
            took = msi_valid_i && msi_ready_o;
            b_valid_i = (c >= 3);
            b_resp_i  = 2'b00;
            if (aw_valid_o && aw_ready_i) aw_log.push_back(aw_addr_o);
            if (done_o) n_done++;
            @(negedge clk_i);
            if (took) msi_valid_i = 1'b0;
        end
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        b_valid_i  = 1'b0;
        chk("fifo_n_done", 64'(n_done), 64'd4);
        chk("fifo_n_aw", 64'(aw_log.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fifo_order%0d", k), (k < aw_log.size()) ? aw_log[k] : '1,
                64'h0000_0000_2400_0000 + 64'((k % 2) * 4096));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
